// File: rtl/imem_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_seq_pkg
//  Description : Shared definitions for the instruction-memory sequencer and
//                its memory array: FSM state encoding, default geometry and
//                instruction width.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_seq_pkg;

    localparam int unsigned DEFAULT_DEPTH = 16;
    localparam int unsigned DEFAULT_AW    = 4;
    localparam int unsigned INSTR_W       = 32;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_READY = 2'd1,
        S_RUN   = 2'd2,
        S_HALT  = 2'd3
    } state_e;

endpackage : imem_seq_pkg
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : imem_ram
//  Description : DEPTH x 32 instruction memory. Synchronous write, asynchronous
//                (combinational) read from the same address port.
//  Ports       : clk_i    - rising-edge clock
//                we_i     - write enable
//                addr_i   - word address (read and write)
//                wdata_i  - write data
//                rdata_o  - read data, combinational from addr_i
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_ram
    import imem_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = DEFAULT_AW
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [AW-1:0]      addr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    output logic [INSTR_W-1:0] rdata_o
);

    // Storage is deliberately not reset: contents survive a sequencer reset.
    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : imem_ram
`default_nettype wire

// File: rtl/imem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_sequencer
//  Description : Controller for the 32-bit instruction memory. Boots the
//                memory from a valid/ready loader stream, then owns the program
//                counter: sequential advance, stall, branch/jump redirect, and
//                halt at end of program or on a bad redirect target.
//  Ports       : clk_i, rst_ni          - clock, async active-low reset
//                ld_valid_i/ld_ready_o  - loader handshake
//                ld_data_i, ld_last_i   - loader word and final-beat marker
//                start_i                - begin execution at pc 0
//                stall_i                - freeze pc / hold instruction
//                redirect_i, redirect_pc_i - branch/jump target (byte address)
//                mem_addr_o, mem_we_o, mem_wdata_o, mem_rdata_i - memory port
//                pc_o, instr_o, instr_valid_o - fetch interface to decode
//                state_o                - FSM state
//                err_o                  - sticky bad-redirect flag
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_sequencer
    import imem_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = DEFAULT_AW
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    // loader stream
    input  logic               ld_valid_i,
    output logic               ld_ready_o,
    input  logic [INSTR_W-1:0] ld_data_i,
    input  logic               ld_last_i,
    // execution control
    input  logic               start_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    // memory port
    output logic [AW-1:0]      mem_addr_o,
    output logic               mem_we_o,
    output logic [INSTR_W-1:0] mem_wdata_o,
    input  logic [INSTR_W-1:0] mem_rdata_i,
    // fetch interface
    output logic [31:0]        pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instr_valid_o,
    output logic [1:0]         state_o,
    output logic               err_o
);

    state_e        state_q;
    logic [31:0]   pc_q;
    logic [AW-1:0] wptr_q;
    logic [AW:0]   prog_len_q;
    logic          err_q;
    logic          ld_ready_q;
    logic          instr_valid_q;

    logic [AW-1:0] w_pc_idx;
    logic [AW-1:0] w_tgt_idx;
    logic          w_accept;
    logic          w_wptr_full;
    logic          w_last_fetch;
    logic          w_tgt_ok;

    assign w_pc_idx    = pc_q[AW+1:2];
    assign w_tgt_idx   = redirect_pc_i[AW+1:2];
    assign w_accept    = ld_valid_i && ld_ready_q;
    // Last slot reached: this beat is forced to be the final one so the
    // write pointer can never wrap onto word 0.
    assign w_wptr_full = (wptr_q == AW'(DEPTH - 1));
    assign w_last_fetch = (({1'b0, w_pc_idx} + (AW+1)'(1)) == prog_len_q);
    // Target must be word aligned, inside the array and inside the program.
    assign w_tgt_ok    = (redirect_pc_i[1:0] == 2'b00)
                      && (redirect_pc_i[31:AW+2] == '0)
                      && ({1'b0, w_tgt_idx} < prog_len_q);

    // ld_ready and instr_valid are registered alongside the state so they
    // always reflect the state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_LOAD;
            pc_q          <= '0;
            wptr_q        <= '0;
            prog_len_q    <= '0;
            err_q         <= 1'b0;
            ld_ready_q    <= 1'b1;
            instr_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (w_accept) begin
                        if (ld_last_i || w_wptr_full) begin
                            prog_len_q <= {1'b0, wptr_q} + (AW+1)'(1);
                            wptr_q     <= '0;
                            state_q    <= S_READY;
                            ld_ready_q <= 1'b0;
                        end else begin
                            wptr_q <= wptr_q + AW'(1);
                        end
                    end
                end
                S_READY: begin
                    if (start_i) begin
                        pc_q          <= '0;
                        state_q       <= S_RUN;
                        instr_valid_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    // While stalled a pending redirect is ignored; the
                    // datapath keeps it asserted until the stall clears.
                    if (!stall_i) begin
                        if (redirect_i) begin
                            if (w_tgt_ok) begin
                                pc_q <= redirect_pc_i;
                            end else begin
                                err_q         <= 1'b1;
                                state_q       <= S_HALT;
                                instr_valid_q <= 1'b0;
                            end
                        end else if (w_last_fetch) begin
                            state_q       <= S_HALT;
                            instr_valid_q <= 1'b0;
                        end else begin
                            pc_q <= pc_q + 32'd4;
                        end
                    end
                end
                S_HALT: begin
                    // start has priority over a waiting loader; the loader
                    // beat seen here is not taken and will be retried.
                    if (start_i) begin
                        pc_q          <= '0;
                        err_q         <= 1'b0;
                        state_q       <= S_RUN;
                        instr_valid_q <= 1'b1;
                    end else if (ld_valid_i) begin
                        wptr_q     <= '0;
                        state_q    <= S_LOAD;
                        ld_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    assign ld_ready_o    = ld_ready_q;
    assign mem_addr_o    = (state_q == S_LOAD) ? wptr_q : w_pc_idx;
    assign mem_we_o      = (state_q == S_LOAD) && w_accept;
    assign mem_wdata_o   = ld_data_i;
    assign pc_o          = pc_q;
    assign instr_o       = mem_rdata_i;
    assign instr_valid_o = instr_valid_q;
    assign state_o       = state_q;
    assign err_o         = err_q;

endmodule : imem_sequencer
`default_nettype wire

// File: tb/tb_imem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_sequencer
//  Description : Self-checking bench for imem_sequencer with imem_ram beside
//                it. Expected fetches are queued when stimulus is driven and
//                compared as the sequencer produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_sequencer;
    import imem_seq_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    localparam logic [31:0] PROG [7] = '{
        32'h00221825, 32'h00221824, 32'hAC010000, 32'h8C240000,
        32'h10210001, 32'h00001820, 32'h00411822
    };

    logic          clk;
    logic          rst_n;
    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          start;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          instr_valid;
    logic [1:0]    state;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        iv;
        logic [1:0]  st;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl_mem [DEPTH];

    imem_sequencer #(.DEPTH(DEPTH), .AW(AW)) u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .ld_valid_i    (ld_valid),
        .ld_ready_o    (ld_ready),
        .ld_data_i     (ld_data),
        .ld_last_i     (ld_last),
        .start_i       (start),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .mem_addr_o    (mem_addr),
        .mem_we_o      (mem_we),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .pc_o          (pc),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .state_o       (state),
        .err_o         (err)
    );

    imem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    // Expected fetch record; instruction comes from the bench's memory model.
    function automatic exp_t mk(input logic [31:0] p, input logic [1:0] s, input logic e);
        exp_t x;
        x.pc    = p;
        x.st    = s;
        x.err   = e;
        x.iv    = (s == 2'd2);
        x.instr = mdl_mem[p[5:2]];
        return x;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (state !== 2'd0 || pc !== 32'd0 || err !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got st=%0d pc=%h err=%b iv=%b, want st=0 pc=0 err=0 iv=0", state, pc, err, instr_valid);
        end
        n_checks++;
        if (ld_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_port: got ld_ready=%b we=%b addr=%0d, want ld_ready=1 we=0 addr=0", ld_ready, mem_we, mem_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_run();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            ld_valid = 1'b1;
            ld_data  = PROG[i];
            ld_last  = (i == 6);
            #1;
            n_checks++;
            if (mem_we !== 1'b1 || mem_addr !== 4'(i) || mem_wdata !== PROG[i]) begin
                n_fail++;
                $display("FAIL load_write beat %0d: got we=%b addr=%0d wdata=%h, want we=1 addr=%0d wdata=%h", i, mem_we, mem_addr, mem_wdata, i, PROG[i]);
            end
            @(negedge clk);
            mdl_mem[i] = PROG[i];
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        n_checks++;
        if (state !== 2'd1 || ld_ready !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ready: got st=%0d ld_ready=%b iv=%b, want st=1 ld_ready=0 iv=0", state, ld_ready, instr_valid);
        end
        start = 1'b1;
        for (int i = 0; i < 7; i++) sb.push_back(mk(32'(i * 4), S_RUN, 1'b0));
        sb.push_back(mk(32'd24, S_HALT, 1'b0));
        while (sb.size() != 0) begin
            @(negedge clk);
            start = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (pc !== e.pc || state !== e.st || instr_valid !== e.iv || err !== e.err || (e.iv && instr !== e.instr)) begin
                n_fail++;
                $display("FAIL run_seq: got pc=%h st=%0d iv=%b err=%b instr=%h, want pc=%h st=%0d iv=%b err=%b instr=%h", pc, state, instr_valid, err, instr, e.pc, e.st, e.iv, e.err, e.instr);
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        start = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(mk(32'(i * 4), S_RUN, 1'b0));
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                // the final push is the stall window at pc 8
            end
            @(negedge clk);
            start = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (pc !== e.pc || state !== e.st || instr_valid !== e.iv || err !== e.err || (e.iv && instr !== e.instr)) begin
                n_fail++;
                $display("FAIL stall_pre: got pc=%h st=%0d iv=%b err=%b instr=%h, want pc=%h st=%0d iv=%b err=%b instr=%h", pc, state, instr_valid, err, instr, e.pc, e.st, e.iv, e.err, e.instr);
            end
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(mk(32'd8, S_RUN, 1'b0));
        for (int i = 3; i < 7; i++) sb.push_back(mk(32'(i * 4), S_RUN, 1'b0));
        sb.push_back(mk(32'd24, S_HALT, 1'b0));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) stall = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (pc !== e.pc || state !== e.st || instr_valid !== e.iv || err !== e.err || (e.iv && instr !== e.instr)) begin
                n_fail++;
                $display("FAIL stall_hold: got pc=%h st=%0d iv=%b err=%b instr=%h, want pc=%h st=%0d iv=%b err=%b instr=%h", pc, state, instr_valid, err, instr, e.pc, e.st, e.iv, e.err, e.instr);
            end
        end
    endtask

    task automatic test_redirect();
        exp_t e;
        // valid redirect 0x04 -> 0x14, then run off the end
        start = 1'b1;
        sb.push_back(mk(32'd0, S_RUN, 1'b0));
        sb.push_back(mk(32'd4, S_RUN, 1'b0));
        sb.push_back(mk(32'h14, S_RUN, 1'b0));
        sb.push_back(mk(32'h18, S_RUN, 1'b0));
        sb.push_back(mk(32'h18, S_HALT, 1'b0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start    = 1'b0;
            redirect = (k == 1);
            redirect_pc = 32'h14;
            e = sb.pop_front();
            n_checks++;
            if (pc !== e.pc || state !== e.st || instr_valid !== e.iv || err !== e.err || (e.iv && instr !== e.instr)) begin
                n_fail++;
                $display("FAIL redir_ok: got pc=%h st=%0d iv=%b err=%b instr=%h, want pc=%h st=%0d iv=%b err=%b instr=%h", pc, state, instr_valid, err, instr, e.pc, e.st, e.iv, e.err, e.instr);
            end
        end
        // out-of-program target 0x1C (index 7) from pc 0x04
        start = 1'b1;
        sb.push_back(mk(32'd0, S_RUN, 1'b0));
        sb.push_back(mk(32'd4, S_RUN, 1'b0));
        sb.push_back(mk(32'd4, S_HALT, 1'b1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start    = 1'b0;
            redirect = (k == 1);
            redirect_pc = 32'h1C;
            e = sb.pop_front();
            n_checks++;
            if (pc !== e.pc || state !== e.st || instr_valid !== e.iv || err !== e.err || (e.iv && instr !== e.instr)) begin
                n_fail++;
                $display("FAIL redir_range: got pc=%h st=%0d iv=%b err=%b instr=%h, want pc=%h st=%0d iv=%b err=%b instr=%h", pc, state, instr_valid, err, instr, e.pc, e.st, e.iv, e.err, e.instr);
            end
        end
        // restart clears err; misaligned 0x06 held through a stall cycle
        start = 1'b1;
        sb.push_back(mk(32'd0, S_RUN, 1'b0));
        sb.push_back(mk(32'd0, S_RUN, 1'b0));
        sb.push_back(mk(32'd0, S_HALT, 1'b1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start       = 1'b0;
            redirect    = (k < 2);
            stall       = (k == 0);
            redirect_pc = 32'h06;
            e = sb.pop_front();
            n_checks++;
            if (pc !== e.pc || state !== e.st || instr_valid !== e.iv || err !== e.err || (e.iv && instr !== e.instr)) begin
                n_fail++;
                $display("FAIL redir_align: got pc=%h st=%0d iv=%b err=%b instr=%h, want pc=%h st=%0d iv=%b err=%b instr=%h", pc, state, instr_valid, err, instr, e.pc, e.st, e.iv, e.err, e.instr);
            end
        end
    endtask

    task automatic test_halt_restart();
        exp_t e;
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (mem_we !== 1'b0 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_nowrite: got we=%b ld_ready=%b, want we=0 ld_ready=0", mem_we, ld_ready);
        end
        sb.push_back(mk(32'd0, S_RUN, 1'b0));
        sb.push_back(mk(32'h18, S_RUN, 1'b0));
        sb.push_back(mk(32'h18, S_HALT, 1'b0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start       = 1'b0;
            ld_valid    = 1'b0;
            redirect    = (k == 0);
            redirect_pc = 32'h18;
            e = sb.pop_front();
            n_checks++;
            if (pc !== e.pc || state !== e.st || instr_valid !== e.iv || err !== e.err || (e.iv && instr !== e.instr)) begin
                n_fail++;
                $display("FAIL halt_start: got pc=%h st=%0d iv=%b err=%b instr=%h, want pc=%h st=%0d iv=%b err=%b instr=%h", pc, state, instr_valid, err, instr, e.pc, e.st, e.iv, e.err, e.instr);
            end
        end
        // loader alone: beat refused in HALT, accepted once in LOAD
        ld_valid = 1'b1;
        ld_data  = 32'h12345678;
        #1;
        n_checks++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_ld_refused: got we=%b, want we=0", mem_we);
        end
        @(negedge clk);
        n_checks++;
        if (state !== 2'd0 || ld_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL halt_to_load: got st=%0d ld_ready=%b we=%b addr=%0d, want st=0 ld_ready=1 we=1 addr=0", state, ld_ready, mem_we, mem_addr);
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_full_load();
        exp_t        e;
        logic [31:0] d;
        for (int i = 0; i < 16; i++) begin
            d        = $urandom;
            ld_valid = 1'b1;
            ld_last  = 1'b0;
            ld_data  = d;
            #1;
            n_checks++;
            if (mem_we !== 1'b1 || mem_addr !== 4'(i)) begin
                n_fail++;
                $display("FAIL full_write beat %0d: got we=%b addr=%0d, want we=1 addr=%0d", i, mem_we, mem_addr, i);
            end
            @(negedge clk);
            mdl_mem[i] = d;
        end
        ld_data = 32'hBADBAD00;
        #1;
        n_checks++;
        if (state !== 2'd1 || ld_ready !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL full_stop: got st=%0d ld_ready=%b we=%b, want st=1 ld_ready=0 we=0", state, ld_ready, mem_we);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        start    = 1'b1;
        for (int i = 0; i < 16; i++) sb.push_back(mk(32'(i * 4), S_RUN, 1'b0));
        sb.push_back(mk(32'h3C, S_HALT, 1'b0));
        while (sb.size() != 0) begin
            @(negedge clk);
            start = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (pc !== e.pc || state !== e.st || instr_valid !== e.iv || err !== e.err || (e.iv && instr !== e.instr)) begin
                n_fail++;
                $display("FAIL full_run: got pc=%h st=%0d iv=%b err=%b instr=%h, want pc=%h st=%0d iv=%b err=%b instr=%h", pc, state, instr_valid, err, instr, e.pc, e.st, e.iv, e.err, e.instr);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t        e;
        logic [31:0] d;
        logic [31:0] w2 [2];
        w2[0] = 32'h0000_1111;
        w2[1] = 32'h2222_0000;
        ld_valid = 1'b1;
        ld_data  = 32'd0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            d       = $urandom;
            ld_data = d;
            @(negedge clk);
            mdl_mem[i] = d;
        end
        ld_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (state !== 2'd0 || ld_ready !== 1'b1 || mem_addr !== 4'd0 || pc !== 32'd0 || instr_valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got st=%0d ld_ready=%b addr=%0d pc=%h iv=%b err=%b, want st=0 ld_ready=1 addr=0 pc=0 iv=0 err=0", state, ld_ready, mem_addr, pc, instr_valid, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = w2[i];
            ld_last  = (i == 1);
            #1;
            n_checks++;
            if (mem_we !== 1'b1 || mem_addr !== 4'(i)) begin
                n_fail++;
                $display("FAIL reload_write beat %0d: got we=%b addr=%0d, want we=1 addr=%0d", i, mem_we, mem_addr, i);
            end
            @(negedge clk);
            mdl_mem[i] = w2[i];
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        start    = 1'b1;
        sb.push_back(mk(32'd0, S_RUN, 1'b0));
        sb.push_back(mk(32'd4, S_RUN, 1'b0));
        sb.push_back(mk(32'd4, S_HALT, 1'b0));
        while (sb.size() != 0) begin
            @(negedge clk);
            start = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (pc !== e.pc || state !== e.st || instr_valid !== e.iv || err !== e.err || (e.iv && instr !== e.instr)) begin
                n_fail++;
                $display("FAIL reload_run: got pc=%h st=%0d iv=%b err=%b instr=%h, want pc=%h st=%0d iv=%b err=%b instr=%h", pc, state, instr_valid, err, instr, e.pc, e.st, e.iv, e.err, e.instr);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        ld_valid    = 1'b0;
        ld_data     = 32'd0;
        ld_last     = 1'b0;
        start       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        for (int i = 0; i < 16; i++) mdl_mem[i] = 32'd0;

        test_reset();
        test_load_run();
        test_stall();
        test_redirect();
        test_halt_restart();
        test_full_load();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_imem_sequencer
`default_nettype wire

// File: doc/imem_sequencer.md
# imem_sequencer

Controller for the processor's 32-bit instruction memory. Boots the memory through a valid/ready loader stream, then owns the program counter and sequences fetches: sequential advance, stall, and branch/jump redirect. It halts at end of program or on a bad target. It sits between the memory array (asynchronous read, synchronous write) and the datapath's decode stage.

## Interface
- DEPTH, 16: instruction words in memory; power of two.
- AW, 4: word-address width, log2(DEPTH).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  loader beat valid.
- ld_ready  out  1  loader beat accepted when ld_valid & ld_ready.
- ld_data  in  32  instruction word to write.
- ld_last  in  1  final beat of program.
- start  in  1  begin execution at pc 0.
- stall  in  1  freeze pc and hold current instruction.
- redirect  in  1  take redirect_pc as next pc.
- redirect_pc  in  32  branch/jump target, byte address.
- mem_addr  out  AW  word address to memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, combinational from mem_addr.
- pc  out  32  current byte pc.
- instr  out  32  fetched instruction, equal to mem_rdata.
- instr_valid  out  1  instr is a live fetch.
- state  out  2  FSM state.
- err  out  1  sticky bad-redirect flag.

## Operation
- States: LOAD=0, READY=1, RUN=2, HALT=3.
- Internal registers: wptr (AW bits) and prog_len (AW+1 bits).
- LOAD:
  - ld_ready=1.
  - mem_we = ld_valid & ld_ready; mem_addr = wptr; mem_wdata = ld_data.
  - On each accepted beat, wptr increments.
  - If the beat has ld_last=1 or wptr==DEPTH-1: prog_len = wptr+1, wptr clears, go to READY. The second condition is a forced last beat; no overflow write ever occurs.
- READY:
  - ld_ready=0, instr_valid=0.
  - start=1: pc=0, go to RUN.
- RUN:
  - mem_addr = pc[AW+1:2]; instr_valid=1; mem_we=0; ld_ready=0.
  - stall=1: pc holds. Redirect is ignored, and the datapath must hold redirect until stall drops.
  - No stall, redirect=1: the target is valid when redirect_pc[1:0]==0, redirect_pc[31:AW+2]==0 and its word index < prog_len. A valid target loads into pc. An invalid target sets err=1 and goes to HALT with pc unchanged.
  - No stall, no redirect: if pc[AW+1:2]+1 == prog_len, go to HALT with pc unchanged. Otherwise pc = pc+4.
- HALT:
  - instr_valid=0; ld_ready=0; pc holds.
  - start=1: pc=0, err=0, go to RUN.
  - Otherwise ld_valid=1: go to LOAD with wptr=0. The beat is not accepted that cycle and the loader retries.
  - start and ld_valid together: start wins.
- LOAD never reads; READY and HALT drive mem_addr = pc[AW+1:2] with mem_we=0.
- pc arithmetic is 32-bit. pc never exceeds (prog_len-1)*4.

## Timing
- Reset values: state=LOAD, pc=0, wptr=0, prog_len=0, err=0, instr_valid=0, ld_ready=1, mem_we=0.
- Reset is asynchronous and may assert mid-load or mid-run. The FSM returns to LOAD immediately. Memory contents are not cleared.
- Write: data is in memory at the edge where ld_valid & ld_ready is high.
- Fetch: instr is valid in the same cycle pc is presented (zero-latency read).
- Latencies:
  - The first instruction is valid 1 cycle after start is sampled.
  - A redirect target is fetched 1 cycle after the redirect is sampled.
- A 1-word program (prog_len=1) runs for exactly 1 cycle, then goes to HALT.

## Structure
- Shared package imem_seq_pkg:
  - state encoding (S_LOAD, S_READY, S_RUN, S_HALT);
  - DEPTH/AW defaults;
  - INSTR_W=32.
- Natural sibling sub-module imem_ram: DEPTH x 32 array with synchronous write and asynchronous read. It is instantiated beside the sequencer at top level; the sequencer contains no storage.

## Test plan
- Load 7 words (0x00221825, 0x00221824, 0xAC010000, 0x8C240000, 0x10210001, 0x00001820, 0x00411822), ld_last on the 7th, then start → pc steps 0,4,…,24 with matching instr. HALT follows after the cycle at pc=24, with instr_valid=0 and err=0.
- Loader holds ld_valid with 16 beats and no ld_last → 16 writes accepted, prog_len=16, ld_ready=0 afterwards.
- Running with stall high for 3 cycles at pc=8 → pc=8 and instr constant for 3 cycles, then pc=12.
- Redirect at pc=4 to 0x14 with prog_len=7 → next pc=0x14. Redirect to 0x1C (index 7) → err=1, HALT, pc=4. Redirect to 0x06 → err=1.
- In HALT, start and ld_valid together → RUN at pc=0 with err cleared. ld_valid alone → LOAD, and the beat is accepted one cycle later.
- Assert rst_n low after 3 load beats → immediate state=LOAD, ld_ready=1, wptr=0. A fresh 2-word load then runs 2 cycles.
